// File: rtl/pattern_counter_pkg.sv
// Shared definitions for the pattern counter: run-mode codes,
// bounce direction and the load-pattern generators.
package pattern_counter_pkg;

    localparam logic [2:0] MODE_UP     = 3'd0;
    localparam logic [2:0] MODE_DOWN   = 3'd1;
    localparam logic [2:0] MODE_SHL    = 3'd2;
    localparam logic [2:0] MODE_ROL    = 3'd3;
    localparam logic [2:0] MODE_ROR    = 3'd4;
    localparam logic [2:0] MODE_BOUNCE = 3'd5;
    localparam logic [2:0] MODE_HOLD   = 3'd6;

    // Widest pattern the generators can produce.
    localparam int PAT_MAX_W = 64;

    typedef enum logic {
        DIR_LEFT  = 1'b0,
        DIR_RIGHT = 1'b1
    } dir_t;

    // Pattern A: every odd bit set below bit position width.
    function automatic logic [PAT_MAX_W-1:0] pattern_a(input int width);
        logic [PAT_MAX_W-1:0] p;
        p = '0;
        for (int i = 1; i < width && i < PAT_MAX_W; i += 2) begin
            p[i] = 1'b1;
        end
        return p;
    endfunction

    // Pattern B: every even bit set below bit position width.
    function automatic logic [PAT_MAX_W-1:0] pattern_b(input int width);
        logic [PAT_MAX_W-1:0] p;
        p = '0;
        for (int i = 0; i < width && i < PAT_MAX_W; i += 2) begin
            p[i] = 1'b1;
        end
        return p;
    endfunction

endpackage

// File: rtl/pattern_counter_gray.sv
// Binary to reflected-Gray encoder for the Gray LED bank.
// Purely combinational; width follows the counter.
module pattern_counter_gray #(
    parameter int WIDTH = 10
) (
    input  logic [WIDTH-1:0] bin,
    output logic [WIDTH-1:0] gray
);

    // Each Gray bit is the XOR of a binary bit and its upper neighbour.
    always_comb begin
        gray = bin ^ (bin >> 1);
    end

endmodule

// File: rtl/pattern_counter.sv
// WIDTH-bit LED pattern generator: prescaler tick, single-step
// edge detect, seven run modes, wrap/saturate and pattern loads.
module pattern_counter
    import pattern_counter_pkg::*;
#(
    parameter int WIDTH = 10,
    parameter int DIV_W = 23,
    parameter bit WRAP  = 1'b1
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             EN,
    input  logic             STEP,
    input  logic [2:0]       MODE,
    input  logic             LOAD_A,
    input  logic             LOAD_B,
    output logic [WIDTH-1:0] CNT,
    output logic [WIDTH-1:0] GRAY,
    output logic             TICK,
    output logic             CARRY
);

    localparam logic [WIDTH-1:0] PAT_A = WIDTH'(pattern_a(WIDTH));
    localparam logic [WIDTH-1:0] PAT_B = WIDTH'(pattern_b(WIDTH));
    localparam logic [WIDTH-1:0] ONES  = '1;
    localparam logic [WIDTH-1:0] ZERO  = '0;
    localparam logic [WIDTH-1:0] ONE   = WIDTH'(1);

    logic [DIV_W-1:0] presc;
    logic             step_q;
    logic             step_evt;
    dir_t             dir;
    dir_t             dir_n;
    logic [WIDTH-1:0] cnt_n;
    logic             carry_n;

    // Prescaler tick on the all-ones count; merge with the STEP edge.
    always_comb begin
        TICK     = &presc;
        step_evt = (EN & TICK) | (STEP & ~step_q);
    end

    // State register: counter, direction, step history, carry, prescaler.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            presc  <= '0;
            step_q <= 1'b0;
            dir    <= DIR_LEFT;
            CNT    <= '0;
            CARRY  <= 1'b0;
        end else begin
            presc  <= presc + 1'b1;
            step_q <= STEP;
            dir    <= dir_n;
            CNT    <= cnt_n;
            CARRY  <= carry_n;
        end
    end

    // Next value: loads win over a step; a step applies the current mode.
    always_comb begin
        cnt_n   = CNT;
        dir_n   = dir;
        carry_n = 1'b0;
        if (LOAD_A) begin
            cnt_n = PAT_A;
        end else if (LOAD_B) begin
            cnt_n = PAT_B;
        end else if (step_evt) begin
            case (MODE)
                MODE_UP: begin
                    if (CNT == ONES) begin
                        carry_n = 1'b1;
                        cnt_n   = WRAP ? ZERO : CNT;
                    end else begin
                        cnt_n = CNT + ONE;
                    end
                end
                MODE_DOWN: begin
                    if (CNT == ZERO) begin
                        carry_n = 1'b1;
                        cnt_n   = WRAP ? ONES : CNT;
                    end else begin
                        cnt_n = CNT - ONE;
                    end
                end
                MODE_SHL: begin
                    cnt_n   = {CNT[WIDTH-2:0], 1'b0};
                    carry_n = CNT[WIDTH-1];
                end
                MODE_ROL: begin
                    cnt_n   = {CNT[WIDTH-2:0], CNT[WIDTH-1]};
                    carry_n = CNT[WIDTH-1];
                end
                MODE_ROR: begin
                    cnt_n   = {CNT[0], CNT[WIDTH-1:1]};
                    carry_n = CNT[0];
                end
                MODE_BOUNCE: begin
                    if (CNT == ZERO) begin
                        cnt_n = ONE;
                        dir_n = DIR_LEFT;
                    end else if (dir == DIR_LEFT && CNT[WIDTH-1]) begin
                        dir_n   = DIR_RIGHT;
                        cnt_n   = CNT >> 1;
                        carry_n = 1'b1;
                    end else if (dir == DIR_RIGHT && CNT[0]) begin
                        dir_n   = DIR_LEFT;
                        cnt_n   = CNT << 1;
                        carry_n = 1'b1;
                    end else if (dir == DIR_LEFT) begin
                        cnt_n = CNT << 1;
                    end else begin
                        cnt_n = CNT >> 1;
                    end
                end
                default: begin
                    cnt_n = CNT;
                end
            endcase
        end
    end

    pattern_counter_gray #(
        .WIDTH(WIDTH)
    ) u_gray (
        .bin (CNT),
        .gray(GRAY)
    );

endmodule

// File: tb/tb_pattern_counter.sv
// Directed bench for pattern_counter (WIDTH=10, DIV_W=4),
// with a wrapping and a saturating instance side by side.
module tb_pattern_counter;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       en = 1'b0;
    logic       step = 1'b0;
    logic [2:0] mode = 3'd0;
    logic       load_a = 1'b0;
    logic       load_b = 1'b0;

    logic [9:0] cnt1, gray1, cnt0, gray0;
    logic       tick1, carry1, tick0, carry0;

    int passed = 0;
    int total = 0;

    always #5 clk = ~clk;

    pattern_counter #(.WIDTH(10), .DIV_W(4), .WRAP(1'b1)) dut_wrap (
        .CLK(clk), .RST(rst), .EN(en), .STEP(step), .MODE(mode),
        .LOAD_A(load_a), .LOAD_B(load_b),
        .CNT(cnt1), .GRAY(gray1), .TICK(tick1), .CARRY(carry1)
    );

    pattern_counter #(.WIDTH(10), .DIV_W(4), .WRAP(1'b0)) dut_sat (
        .CLK(clk), .RST(rst), .EN(en), .STEP(step), .MODE(mode),
        .LOAD_A(load_a), .LOAD_B(load_b),
        .CNT(cnt0), .GRAY(gray0), .TICK(tick0), .CARRY(carry0)
    );

    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic do_reset;
        rst = 1'b1;
        cyc(2);
        rst = 1'b0;
    endtask

    // One low cycle, then one edge; returns just after the step edge.
    task automatic pulse_step;
        step = 1'b0;
        cyc(1);
        step = 1'b1;
        cyc(1);
        step = 1'b0;
    endtask

    task automatic test_reset_tick;
        en = 1'b0; step = 1'b0; mode = 3'd0;
        rst = 1'b1;
        cyc(2);
        total++; if (cnt1 !== 10'h000) $display("FAIL rst_cnt got %h want 000", cnt1); else passed++;
        total++; if (carry1 !== 1'b0) $display("FAIL rst_carry got %b want 0", carry1); else passed++;
        total++; if (tick1 !== 1'b0) $display("FAIL rst_tick got %b want 0", tick1); else passed++;
        total++; if (gray1 !== 10'h000) $display("FAIL rst_gray got %h want 000", gray1); else passed++;
        en = 1'b1;
        rst = 1'b0;
        cyc(14);
        total++; if (tick1 !== 1'b0) $display("FAIL tick_early got %b want 0", tick1); else passed++;
        cyc(1);
        total++; if (tick1 !== 1'b1) $display("FAIL tick15 got %b want 1", tick1); else passed++;
        total++; if (cnt1 !== 10'h000) $display("FAIL cnt_pre_tick got %h want 000", cnt1); else passed++;
        cyc(1);
        total++; if (cnt1 !== 10'h001) $display("FAIL cnt_t1 got %h want 001", cnt1); else passed++;
        total++; if (gray1 !== 10'h001) $display("FAIL gray_t1 got %h want 001", gray1); else passed++;
        total++; if (tick1 !== 1'b0) $display("FAIL tick16 got %b want 0", tick1); else passed++;
        cyc(15);
        total++; if (tick1 !== 1'b1) $display("FAIL tick31 got %b want 1", tick1); else passed++;
        cyc(1);
        total++; if (cnt1 !== 10'h002) $display("FAIL cnt_t2 got %h want 002", cnt1); else passed++;
        total++; if (gray1 !== 10'h003) $display("FAIL gray_t2 got %h want 003", gray1); else passed++;
        cyc(16);
        total++; if (cnt1 !== 10'h003) $display("FAIL cnt_t3 got %h want 003", cnt1); else passed++;
        total++; if (gray1 !== 10'h002) $display("FAIL gray_t3 got %h want 002", gray1); else passed++;
        total++; if (cnt0 !== 10'h003) $display("FAIL sat_cnt_t3 got %h want 003", cnt0); else passed++;
        en = 1'b0;
    endtask

    task automatic test_wrap_saturate;
        do_reset();
        mode = 3'd0;
        load_a = 1'b1;
        cyc(1);
        load_a = 1'b0;
        total++; if (cnt1 !== 10'h2AA) $display("FAIL load_a got %h want 2aa", cnt1); else passed++;
        for (int i = 0; i < 341; i++) pulse_step();
        total++; if (cnt1 !== 10'h3FF) $display("FAIL up_to_max got %h want 3ff", cnt1); else passed++;
        total++; if (cnt0 !== 10'h3FF) $display("FAIL sat_up_to_max got %h want 3ff", cnt0); else passed++;
        pulse_step();
        total++; if (cnt1 !== 10'h000) $display("FAIL up_wrap got %h want 000", cnt1); else passed++;
        total++; if (carry1 !== 1'b1) $display("FAIL up_wrap_carry got %b want 1", carry1); else passed++;
        total++; if (cnt0 !== 10'h3FF) $display("FAIL up_sat got %h want 3ff", cnt0); else passed++;
        total++; if (carry0 !== 1'b1) $display("FAIL up_sat_carry got %b want 1", carry0); else passed++;
        cyc(1);
        total++; if (carry1 !== 1'b0) $display("FAIL carry_drop got %b want 0", carry1); else passed++;
        total++; if (carry0 !== 1'b0) $display("FAIL sat_carry_drop got %b want 0", carry0); else passed++;
        mode = 3'd1;
        pulse_step();
        total++; if (cnt1 !== 10'h3FF) $display("FAIL down_wrap got %h want 3ff", cnt1); else passed++;
        total++; if (carry1 !== 1'b1) $display("FAIL down_wrap_carry got %b want 1", carry1); else passed++;
        total++; if (cnt0 !== 10'h3FE) $display("FAIL sat_down got %h want 3fe", cnt0); else passed++;
        total++; if (carry0 !== 1'b0) $display("FAIL sat_down_carry got %b want 0", carry0); else passed++;
        do_reset();
        pulse_step();
        total++; if (cnt0 !== 10'h000) $display("FAIL down_sat got %h want 000", cnt0); else passed++;
        total++; if (carry0 !== 1'b1) $display("FAIL down_sat_carry got %b want 1", carry0); else passed++;
        total++; if (cnt1 !== 10'h3FF) $display("FAIL down_wrap0 got %h want 3ff", cnt1); else passed++;
    endtask

    task automatic test_loads;
        step = 1'b0;
        cyc(1);
        load_a = 1'b1; load_b = 1'b1; step = 1'b1;
        cyc(1);
        total++; if (cnt1 !== 10'h2AA) $display("FAIL load_prio got %h want 2aa", cnt1); else passed++;
        total++; if (carry1 !== 1'b0) $display("FAIL load_carry got %b want 0", carry1); else passed++;
        load_a = 1'b0;
        cyc(1);
        total++; if (cnt1 !== 10'h155) $display("FAIL load_b got %h want 155", cnt1); else passed++;
        load_b = 1'b0; step = 1'b0;
        mode = 3'd2;
        pulse_step();
        total++; if (cnt1 !== 10'h2AA) $display("FAIL shl1 got %h want 2aa", cnt1); else passed++;
        total++; if (carry1 !== 1'b0) $display("FAIL shl1_carry got %b want 0", carry1); else passed++;
        pulse_step();
        total++; if (cnt1 !== 10'h154) $display("FAIL shl2 got %h want 154", cnt1); else passed++;
        total++; if (carry1 !== 1'b1) $display("FAIL shl2_carry got %b want 1", carry1); else passed++;
        mode = 3'd6;
        pulse_step();
        total++; if (cnt1 !== 10'h154) $display("FAIL hold6 got %h want 154", cnt1); else passed++;
        total++; if (carry1 !== 1'b0) $display("FAIL hold6_carry got %b want 0", carry1); else passed++;
        mode = 3'd7;
        pulse_step();
        total++; if (cnt1 !== 10'h154) $display("FAIL hold7 got %h want 154", cnt1); else passed++;
    endtask

    task automatic test_single_step;
        int n;
        do_reset();
        mode = 3'd0;
        repeat (3) pulse_step();
        mode = 3'd4;
        pulse_step();
        total++; if (cnt1 !== 10'h201) $display("FAIL ror got %h want 201", cnt1); else passed++;
        total++; if (carry1 !== 1'b1) $display("FAIL ror_carry got %b want 1", carry1); else passed++;
        mode = 3'd3;
        step = 1'b0;
        cyc(1);
        step = 1'b1;
        cyc(1);
        total++; if (cnt1 !== 10'h003) $display("FAIL rol got %h want 003", cnt1); else passed++;
        total++; if (carry1 !== 1'b1) $display("FAIL rol_carry got %b want 1", carry1); else passed++;
        cyc(9);
        total++; if (cnt1 !== 10'h003) $display("FAIL step_held got %h want 003", cnt1); else passed++;
        total++; if (carry1 !== 1'b0) $display("FAIL step_held_carry got %b want 0", carry1); else passed++;
        step = 1'b0;
        cyc(1);
        n = 0;
        while (tick1 !== 1'b1 && n < 40) begin
            cyc(1);
            n++;
        end
        total++; if (tick1 !== 1'b1) $display("FAIL tick_wait got %b want 1", tick1); else passed++;
        en = 1'b1; step = 1'b1;
        cyc(1);
        total++; if (cnt1 !== 10'h006) $display("FAIL coincide got %h want 006", cnt1); else passed++;
        total++; if (cnt0 !== 10'h006) $display("FAIL sat_coincide got %h want 006", cnt0); else passed++;
        en = 1'b0; step = 1'b0;
        cyc(1);
        total++; if (cnt1 !== 10'h006) $display("FAIL coincide_after got %h want 006", cnt1); else passed++;
    endtask

    task automatic test_bounce;
        logic [9:0] exp;
        do_reset();
        mode = 3'd5;
        pulse_step();
        total++; if (cnt1 !== 10'h001) $display("FAIL bounce0 got %h want 001", cnt1); else passed++;
        for (int i = 1; i <= 9; i++) begin
            pulse_step();
            exp = 10'h001 << i;
            total++; if (cnt1 !== exp) $display("FAIL bounce_up got %h want %h", cnt1, exp); else passed++;
        end
        total++; if (carry1 !== 1'b0) $display("FAIL bounce_up_carry got %b want 0", carry1); else passed++;
        pulse_step();
        total++; if (cnt1 !== 10'h100) $display("FAIL bounce_rev got %h want 100", cnt1); else passed++;
        total++; if (carry1 !== 1'b1) $display("FAIL bounce_rev_carry got %b want 1", carry1); else passed++;
        for (int i = 7; i >= 0; i--) begin
            pulse_step();
            exp = 10'h001 << i;
            total++; if (cnt1 !== exp) $display("FAIL bounce_dn got %h want %h", cnt1, exp); else passed++;
        end
        pulse_step();
        total++; if (cnt1 !== 10'h002) $display("FAIL bounce_lo got %h want 002", cnt1); else passed++;
        total++; if (carry1 !== 1'b1) $display("FAIL bounce_lo_carry got %b want 1", carry1); else passed++;
        pulse_step();
        total++; if (cnt1 !== 10'h004) $display("FAIL bounce_left got %h want 004", cnt1); else passed++;
        total++; if (carry1 !== 1'b0) $display("FAIL bounce_left_carry got %b want 0", carry1); else passed++;
    endtask

    task automatic test_async_reset;
        do_reset();
        mode = 3'd5;
        repeat (11) pulse_step();
        total++; if (cnt1 !== 10'h100) $display("FAIL ar_setup got %h want 100", cnt1); else passed++;
        load_b = 1'b1;
        cyc(1);
        load_b = 1'b0;
        total++; if (cnt1 !== 10'h155) $display("FAIL ar_load got %h want 155", cnt1); else passed++;
        #2;
        rst = 1'b1;
        #1;
        total++; if (cnt1 !== 10'h000) $display("FAIL ar_clear got %h want 000", cnt1); else passed++;
        total++; if (cnt0 !== 10'h000) $display("FAIL sat_ar_clear got %h want 000", cnt0); else passed++;
        cyc(1);
        rst = 1'b0;
        pulse_step();
        total++; if (cnt1 !== 10'h001) $display("FAIL ar_first got %h want 001", cnt1); else passed++;
        pulse_step();
        total++; if (cnt1 !== 10'h002) $display("FAIL ar_second got %h want 002", cnt1); else passed++;
        total++; if (carry1 !== 1'b0) $display("FAIL ar_dir_carry got %b want 0", carry1); else passed++;
    endtask

    initial begin
        test_reset_tick();
        test_wrap_saturate();
        test_loads();
        test_single_step();
        test_bounce();
        test_async_reset();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
